// File: rtl/std_fp_pkg.sv
// Shared types for the signed fixed-point divider: FSM state encoding and
// the width of the iteration counter.
package std_fp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int width, input int frac_width);
      return $clog2(width + frac_width + 1);
   endfunction

endpackage

// File: rtl/std_fp_udiv_iter.sv
// Unsigned restoring divider producing one quotient bit per clock.
// The first step is taken on the start edge so the last one lands N-1 edges later.
module std_fp_udiv_iter
   import std_fp_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int FRAC_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [WIDTH+FRAC_WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]            divisor,
   output logic                        busy,
   output logic [WIDTH+FRAC_WIDTH-1:0] quotient
);

   localparam int            N    = WIDTH + FRAC_WIDTH;
   localparam int            CW   = cnt_width(WIDTH, FRAC_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(N - 2);

   logic [WIDTH-1:0] rem_q, dvsr_q, src_rem, src_dvsr, rem_d;
   logic [N-1:0]     work_q, src_work, work_d;
   logic [WIDTH:0]   trial;
   logic             qbit;
   logic [CW-1:0]    cnt_q;
   logic             active_q;

   // Dividend bits shift out of the top of work_q while quotient bits shift in below.
   always_comb begin
      src_rem  = start ? '0       : rem_q;
      src_work = start ? dividend : work_q;
      src_dvsr = start ? divisor  : dvsr_q;
      trial    = {src_rem, src_work[N-1]};
      qbit     = (trial >= {1'b0, src_dvsr});
      rem_d    = qbit ? (trial[WIDTH-1:0] - src_dvsr) : trial[WIDTH-1:0];
      work_d   = {src_work[N-2:0], qbit};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start) begin
         cnt_q    <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == LAST) active_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (start || active_q) begin
         rem_q  <= rem_d;
         work_q <= work_d;
      end
      if (start) dvsr_q <= divisor;
   end

   assign busy     = active_q;
   assign quotient = work_q;

endmodule

// File: rtl/std_fp_sdiv_pipe.sv
// Signed fixed-point divider: sign handling and go/done handshake around the iterative core.
// Define STD_FP_SDIV_SAT_EN to saturate on overflow and divide-by-zero instead of wrapping.
module std_fp_sdiv_pipe
   import std_fp_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int INT_WIDTH  = 16,
   parameter int FRAC_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    go,
   input  logic signed [WIDTH-1:0] left,
   input  logic signed [WIDTH-1:0] right,
   output logic signed [WIDTH-1:0] out,
   output logic                    done,
   output logic                    div_zero
);

   localparam int N        = WIDTH + FRAC_WIDTH;
   localparam int SIGN_BIT = INT_WIDTH + FRAC_WIDTH - 1;

   state_t                  state_q;
   logic                    neg_q, rz_q, done_q, dz_q;
   logic signed [WIDTH-1:0] out_q;
   logic                    start, busy, ovf;
   logic [N-1:0]            quot;
   logic [WIDTH-1:0]        q_lo, q_neg, res;

   // Unsigned magnitude at full width, so the most-negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
      return x[WIDTH-1] ? (~$unsigned(x) + WIDTH'(1)) : $unsigned(x);
   endfunction

   assign start = go && (state_q == IDLE || state_q == DONE);

   std_fp_udiv_iter #(
      .WIDTH      (WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH)
   ) u_iter (
      .clk      (clk),
      .rst_n    (reset),
      .start    (start),
      .dividend ({mag(left), {FRAC_WIDTH{1'b0}}}),
      .divisor  (mag(right)),
      .busy     (busy),
      .quotient (quot)
   );

`ifdef STD_FP_SDIV_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`else
   logic unused_ovf;
   assign unused_ovf = ovf;
`endif

   always_comb begin
      q_lo  = quot[WIDTH-1:0];
      q_neg = ~q_lo + WIDTH'(1);
      // A negative result may reach exactly -2^(WIDTH-1); a positive one may not.
      ovf   = (|quot[N-1:WIDTH]) ||
              (neg_q ? (q_lo[SIGN_BIT] && (|q_lo[SIGN_BIT-1:0])) : q_lo[SIGN_BIT]);
`ifdef STD_FP_SDIV_SAT_EN
      if (rz_q || ovf) res = neg_q ? SAT_NEG : SAT_POS;
      else             res = neg_q ? q_neg : q_lo;
`else
      res = rz_q ? '0 : (neg_q ? q_neg : q_lo);
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         out_q   <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         neg_q   <= 1'b0;
         rz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (go) begin
                  state_q <= RUN;
                  neg_q   <= left[WIDTH-1] ^ right[WIDTH-1];
                  rz_q    <= (right == '0);
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               if (!go) begin
                  state_q <= IDLE;
               end else if (!busy) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  out_q   <= res;
                  dz_q    <= rz_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out      = out_q;
   assign done     = done_q;
   assign div_zero = dz_q;

endmodule

// File: doc/std_fp_sdiv_pipe.md
STD_FP_SDIV_PIPE -- requirements
Module: std_fp_sdiv_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: total operand and result width in bits.
REQ-002 SHALL have parameter INT_WIDTH, default 16: integer bits, sign bit included.
REQ-003 SHALL have parameter FRAC_WIDTH, default 16: fraction bits; WIDTH = INT_WIDTH + FRAC_WIDTH.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port go  input  1: start request; the caller holds it high until done.
REQ-007 SHALL have port left  input  WIDTH: signed fixed-point dividend.
REQ-008 SHALL have port right  input  WIDTH: signed fixed-point divisor.
REQ-009 SHALL have port out  output  WIDTH: signed fixed-point quotient, same format as the operands.
REQ-010 SHALL have port done  output  1: one-cycle completion pulse.
REQ-011 SHALL have port div_zero  output  1: set when right was 0; valid while done is high.

Function
REQ-012 SHALL compute (|left| << FRAC_WIDTH) / |right| with an unsigned restoring divide, one quotient bit per cycle, over N = WIDTH + FRAC_WIDTH iterations.
REQ-013 SHALL compute magnitudes at WIDTH bits unsigned, so the most-negative operand is handled without overflow.
REQ-014 SHALL negate the quotient magnitude when left[WIDTH-1] XOR right[WIDTH-1] is 1; rounding is truncation toward zero.
REQ-015 SHALL use the FSM states IDLE, RUN and DONE.
REQ-016 IDLE -> RUN on the first edge with go=1: the block captures left, right and their signs, and clears the iteration counter.
REQ-017 RUN SHALL last exactly N cycles, then move to DONE.
REQ-018 DONE SHALL hold for one cycle with done=1 and out/div_zero updated, then return to IDLE.
REQ-019 Latency: done SHALL be high in the N+1st cycle after the go-sampling edge.
REQ-020 In RUN or DONE, go=0 at an edge SHALL abort the operation: go to IDLE, do not assert done, and leave out and div_zero unchanged.
REQ-021 go still high in the cycle after DONE SHALL start a new operation, with operands sampled at that edge.
REQ-022 out SHALL change only on completion and SHALL hold the last completed result otherwise.
REQ-023 When right=0, the block SHALL set div_zero=1, keep the same latency, and drive out per REQ-027/REQ-028.
REQ-024 Overflow is any nonzero quotient magnitude bit above bit WIDTH-1, or a magnitude exceeding the signed range.

Reset
REQ-025 When reset=0, the block SHALL immediately force the state to IDLE and set out=0, done=0, div_zero=0 and the counter to 0, regardless of clock.
REQ-026 Reset asserted mid-RUN SHALL discard the operation; after release, the block SHALL wait for go sampled high.

Configuration
REQ-027 With STD_FP_SDIV_SAT_EN defined, overflow and divide-by-zero SHALL drive out=2^(WIDTH-1)-1 for a non-negative result sign, or -2^(WIDTH-1) for a negative sign.
REQ-028 Without STD_FP_SDIV_SAT_EN, out SHALL be the low WIDTH bits of the signed quotient (wrap), and divide-by-zero SHALL give out=0.

Structure
REQ-029 Package std_fp_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the iteration-count width function, clog2 of WIDTH+FRAC_WIDTH+1.
REQ-030 Sub-module std_fp_udiv_iter SHALL hold the unsigned shift/subtract core (start, busy, quotient); the top level SHALL handle sign, saturation and the handshake.

Verification (WIDTH=32, INT_WIDTH=16, FRAC_WIDTH=16, N=48)
REQ-031 0x00060000 / 0x00020000 (6.0/2.0), go held -> done in cycle 49, out=0x00030000, div_zero=0.
REQ-032 0xFFF88000 / 0x00020000 (-7.5/2.0) -> out=0xFFFC4000; 0x00010000 / 0xFFFD0000 (1/-3) -> out=0xFFFFAAAB (truncated toward zero).
REQ-033 0x7FFF0000 / 0x00000001 -> out=0x7FFFFFFF with STD_FP_SDIV_SAT_EN; out=0x00000000 without it.
REQ-034 0xFFFB0000 / 0 -> div_zero=1, out=0x80000000 with STD_FP_SDIV_SAT_EN; out=0 without it.
REQ-035 go dropped at cycle 10 of RUN -> no done pulse, out keeps its previous value; a new go then gives a correct result after N+1 cycles.
REQ-036 reset pulsed low mid-RUN, asynchronous to clk -> out=0, done=0 immediately; a subsequent 6.0/2.0 gives 0x00030000.
